alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one combinational 4-bit ALU (alu_behavioral) between two requesters.
//  Grants one request at a time, round-robin or fixed priority, with valid/ready handshakes.
//  Registers the operands and the result, and returns the 8-bit result tagged with the requester ID.
//  Sits between the two command sources and the single ALU instance.
// PARAMETERS
//  RR_EN   1  1 = round-robin arbitration, 0 = fixed priority (req0 wins)
//  OP_W    4  operand width; fixed at 4 to match the ALU (elaboration error otherwise)
//  CTRL_W  3  opcode width; fixed at 3
// PORTS
//  i_clk          in   1  clock, single domain
//  i_rst          in   1  synchronous, active-high reset
//  i_req0_valid   in   1  requester 0 has a command
//  i_req0_op1     in   4  requester 0 operand 1
//  i_req0_op2     in   4  requester 0 operand 2
//  i_req0_ctrl    in   3  requester 0 opcode (0 ADD, 1 SUB, 2 MUL, 3 NAND, 4 NOR)
//  o_req0_ready   out  1  requester 0 command accepted this cycle
//  i_req1_valid   in   1  requester 1 has a command
//  i_req1_op1     in   4  requester 1 operand 1
//  i_req1_op2     in   4  requester 1 operand 2
//  i_req1_ctrl    in   3  requester 1 opcode
//  o_req1_ready   out  1  requester 1 command accepted this cycle
//  o_resp_valid   out  1  result available
//  i_resp_ready   in   1  consumer takes the result
//  o_resp_id      out  1  requester that issued the result
//  o_resp_err     out  1  opcode was illegal (5..7)
//  o_dat          out  8  ALU result
//  o_busy         out  1  a command is in flight (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer = 0 (req0 preferred). Operand and result registers cleared.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//    - o_reqN_ready is asserted combinationally, for the winner only, when any valid is high.
//    - Acceptance = valid & ready. On acceptance, latch op1/op2/ctrl/id and go to EXEC.
//   EXEC:
//    - ALU inputs are driven from the latched operands.
//    - Latch o_dat <= ALU output and o_resp_err <= (ctrl > 4); go to RESP.
//   RESP:
//    - o_resp_valid = 1; o_dat, o_resp_id and o_resp_err stay stable.
//    - When i_resp_ready = 1, go to IDLE.
//    - i_resp_ready while not in RESP is ignored.
//  Latency: accept at cycle N, o_resp_valid at N+2. Peak throughput is 1 op per 3 cycles.
//  Arbitration:
//   - Only one valid: that requester wins.
//   - Both valid, RR_EN=1: winner = RR pointer; the pointer moves to the other requester on each grant.
//   - Both valid, RR_EN=0: req0 always wins.
//  Starvation: with RR_EN=1, a requester holding valid is granted within 2 grants.
//  Protocol: a requester holds valid and its fields stable until ready. Dropping valid early is legal and simply withdraws the request.
//  Result rules (identical to the ALU):
//   - ADD, SUB, NAND, NOR: result in [3:0], upper nibble 0; SUB wraps mod 16.
//   - MUL: full 8-bit product.
//   - Illegal opcode: o_dat = 0 and o_resp_err = 1.
//  o_dat holds its last value in IDLE and is only meaningful while o_resp_valid = 1.
//  A request arriving during EXEC/RESP gets no ready; it stays pending and is arbitrated in the next IDLE.
//  i_rst mid-operation: the in-flight command is discarded with no response, and the FSM returns to IDLE on the next edge.
// STRUCTURE
//  Shared include alu_pkg.vh:
//   - opcode localparams ALU_ADD..ALU_NOR and ALU_OP_MAX = 4
//   - FSM state encodings S_IDLE/S_EXEC/S_RESP (2 bits)
//  One sub-module: alu_behavioral, instantiated once and fed from the operand registers.
//  Arbiter logic (pointer + grant) stays inline; there is no separate arbiter module.
// TESTING
//  1. req0 op1=3 op2=5 ctrl=0, resp_ready=1 -> o_req0_ready same cycle; o_resp_valid 2 cycles later; o_dat=0x08, id=0, err=0.
//  2. req1 SUB 2,5 then MUL 15,15 -> o_dat=0x0D, then 0xE1; id=1 for both.
//  3. Both valid every cycle, RR_EN=1, 4 ops -> grants alternate 0,1,0,1. With RR_EN=0 -> all four grants go to req0.
//  4. NAND 0xC,0xA held with resp_ready=0 for 5 cycles -> o_resp_valid and o_dat=0x07 stable; no new ready until the cycle after resp_ready=1.
//  5. ctrl=6 -> o_dat=0x00, o_resp_err=1; following NOR 0x0,0x0 -> o_dat=0x0F, err=0.
//  6. Assert i_rst during EXEC -> next cycle state IDLE, o_resp_valid=0, o_busy=0; that command never returns a response.

Source files
------------

// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   - operand/opcode/result widths
//   - ALU opcode encodings and the highest legal opcode
//   - arbiter FSM state type
package alu_req_arbiter_pkg;

  localparam int unsigned OpW   = 4;
  localparam int unsigned CtrlW = 3;
  localparam int unsigned ResW  = 8;

  localparam logic [CtrlW-1:0] AluAdd   = 3'd0;
  localparam logic [CtrlW-1:0] AluSub   = 3'd1;
  localparam logic [CtrlW-1:0] AluMul   = 3'd2;
  localparam logic [CtrlW-1:0] AluNand  = 3'd3;
  localparam logic [CtrlW-1:0] AluNor   = 3'd4;
  localparam logic [CtrlW-1:0] AluOpMax = 3'd4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu_behavioral.sv
// Combinational 4-bit ALU.
//   op1_i, op2_i : 4-bit operands
//   ctrl_i       : opcode (ADD, SUB, MUL, NAND, NOR; 5..7 illegal)
//   res_o        : 8-bit result; logic ops and ADD/SUB use the low nibble only,
//                  MUL returns the full product, illegal opcodes return 0
module alu_behavioral
  import alu_req_arbiter_pkg::*;
(
  input  logic [OpW-1:0]   op1_i,
  input  logic [OpW-1:0]   op2_i,
  input  logic [CtrlW-1:0] ctrl_i,
  output logic [ResW-1:0]  res_o
);

  logic [OpW-1:0] nib;

  always_comb begin
    nib   = '0;
    res_o = '0;
    unique case (ctrl_i)
      AluAdd:  nib = op1_i + op2_i;
      AluSub:  nib = op1_i - op2_i;
      AluNand: nib = ~(op1_i & op2_i);
      AluNor:  nib = ~(op1_i | op2_i);
      default: nib = '0;
    endcase
    if (ctrl_i == AluMul) begin
      res_o = {4'b0, op1_i} * {4'b0, op2_i};
    end else begin
      res_o = {4'b0, nib};
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates two valid/ready command sources onto one shared ALU.
//   i_clk, i_rst         : clock and synchronous active-high reset
//   i_reqN_*             : requester N command (valid, op1, op2, ctrl)
//   o_reqN_ready         : requester N command accepted this cycle
//   o_resp_valid/i_resp_ready : result handshake
//   o_resp_id, o_resp_err, o_dat : tagged result, stable while o_resp_valid
//   o_busy               : a command is in flight
// One command at a time: IDLE (accept) -> EXEC (compute) -> RESP (hold result).
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN  = 1,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [OP_W-1:0]   i_req0_op1,
  input  logic [OP_W-1:0]   i_req0_op2,
  input  logic [CTRL_W-1:0] i_req0_ctrl,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [OP_W-1:0]   i_req1_op1,
  input  logic [OP_W-1:0]   i_req1_op2,
  input  logic [CTRL_W-1:0] i_req1_ctrl,
  output logic              o_req1_ready,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic              o_resp_id,
  output logic              o_resp_err,
  output logic [7:0]        o_dat,
  output logic              o_busy
);

  if (OP_W != OpW || CTRL_W != CtrlW) begin : g_width_check
    $error("alu_req_arbiter: OP_W must be 4 and CTRL_W must be 3");
  end

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              id_q, id_d;
  logic [ResW-1:0]   dat_q, dat_d;
  logic              err_q, err_d;
  logic [ResW-1:0]   alu_res;
  logic              grant_id;
  logic              accept;

  alu_behavioral u_alu (
    .op1_i  (op1_q),
    .op2_i  (op2_q),
    .ctrl_i (ctrl_q),
    .res_o  (alu_res)
  );

  // A lone requester always wins; contention goes to the pointer or to req0.
  always_comb begin
    grant_id = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_id = (RR_EN != 0) ? rr_ptr_q : 1'b0;
    end else begin
      grant_id = i_req1_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    ctrl_d       = ctrl_q;
    id_d         = id_q;
    dat_d        = dat_q;
    err_d        = err_q;
    accept       = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_resp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_req0_ready = i_req0_valid & ~grant_id;
        o_req1_ready = i_req1_valid & grant_id;
        accept       = i_req0_valid | i_req1_valid;
        if (accept) begin
          op1_d    = grant_id ? i_req1_op1  : i_req0_op1;
          op2_d    = grant_id ? i_req1_op2  : i_req0_op2;
          ctrl_d   = grant_id ? i_req1_ctrl : i_req0_ctrl;
          id_d     = grant_id;
          rr_ptr_d = ~grant_id;
          state_d  = StExec;
        end
      end
      StExec: begin
        dat_d   = alu_res;
        err_d   = (ctrl_q > AluOpMax);
        state_d = StResp;
      end
      StResp: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      ctrl_q   <= '0;
      id_q     <= 1'b0;
      dat_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      ctrl_q   <= ctrl_d;
      id_q     <= id_d;
      dat_q    <= dat_d;
      err_q    <= err_d;
    end
  end

  assign o_resp_id  = id_q;
  assign o_resp_err = err_q;
  assign o_dat      = dat_q;
  assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, resp_ready;
  logic [3:0] a0, b0, a1, b1;
  logic [2:0] c0, c1;

  logic       r_rdy0, r_rdy1, r_rv, r_id, r_err, r_busy;
  logic       f_rdy0, f_rdy1, f_rv, f_id, f_err, f_busy;
  logic [7:0] r_dat, f_dat;

  int tests = 0;
  int fails = 0;
  bit rr_pref;  // requester the round-robin DUT favours on contention

  always #5 clk = ~clk;

  alu_req_arbiter #(.RR_EN(1)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_op1(a0), .i_req0_op2(b0), .i_req0_ctrl(c0),
    .o_req0_ready(r_rdy0),
    .i_req1_valid(v1), .i_req1_op1(a1), .i_req1_op2(b1), .i_req1_ctrl(c1),
    .o_req1_ready(r_rdy1),
    .o_resp_valid(r_rv), .i_resp_ready(resp_ready), .o_resp_id(r_id),
    .o_resp_err(r_err), .o_dat(r_dat), .o_busy(r_busy)
  );

  alu_req_arbiter #(.RR_EN(0)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_op1(a0), .i_req0_op2(b0), .i_req0_ctrl(c0),
    .o_req0_ready(f_rdy0),
    .i_req1_valid(v1), .i_req1_op1(a1), .i_req1_op2(b1), .i_req1_ctrl(c1),
    .o_req1_ready(f_rdy1),
    .o_resp_valid(f_rv), .i_resp_ready(resp_ready), .o_resp_id(f_id),
    .o_resp_err(f_err), .o_dat(f_dat), .o_busy(f_busy)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result as {err, dat} from plain integer arithmetic.
  function automatic logic [8:0] model(input int a, input int b, input int c);
    int r;
    bit e;
    e = 1'b0;
    case (c)
      0:       r = (a + b) % 16;
      1:       r = (a - b + 16) % 16;
      2:       r = a * b;
      3:       r = 15 - (a & b);
      4:       r = 15 - (a | b);
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, r[7:0]};
  endfunction

  // Entered #1 after a rising edge with both DUTs idle and requests already driven.
  task automatic transact(input int hold, input bit keep);
    bit w_rr, w_fp;
    logic [8:0] e_rr, e_fp;
    w_fp = v0 ? 1'b0 : 1'b1;
    w_rr = (v0 && v1) ? rr_pref : !v0;
    e_rr = w_rr ? model(a1, b1, c1) : model(a0, b0, c0);
    e_fp = w_fp ? model(a1, b1, c1) : model(a0, b0, c0);
    #1;
    chk("rr_ready", {7'b0, r_rdy1, r_rdy0}, {7'b0, v1 && w_rr, v0 && !w_rr});
    chk("fp_ready", {7'b0, f_rdy1, f_rdy0}, {7'b0, v1 && w_fp, v0 && !w_fp});
    @(posedge clk); #1;
    rr_pref = !w_rr;
    if (!keep) begin v0 = 1'b0; v1 = 1'b0; end
    resp_ready = 1'($urandom % 2);  // must be ignored outside RESP
    #1;
    chk("exec_busy", {7'b0, r_busy, f_busy}, 9'b11);
    chk("exec_rv", {7'b0, r_rv, f_rv}, 9'b0);
    chk("exec_ready", {5'b0, r_rdy0, r_rdy1, f_rdy0, f_rdy1}, 9'b0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    #1;
    chk("rr_rv", {8'b0, r_rv}, 9'd1);
    chk("fp_rv", {8'b0, f_rv}, 9'd1);
    chk("rr_res", {r_err, r_dat}, e_rr);
    chk("fp_res", {f_err, f_dat}, e_fp);
    chk("rr_id", {8'b0, r_id}, {8'b0, w_rr});
    chk("fp_id", {8'b0, f_id}, {8'b0, w_fp});
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_rv", {7'b0, r_rv, f_rv}, 9'b11);
      chk("hold_res", {r_err, r_dat}, e_rr);
      chk("hold_ready", {7'b0, r_rdy0, r_rdy1}, 9'b0);
    end
    resp_ready = 1'b1;
    #1;
    chk("release_ready", {5'b0, r_rdy0, r_rdy1, f_rdy0, f_rdy1}, 9'b0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("done_busy", {7'b0, r_busy, f_busy}, 9'b0);
    chk("done_rv", {7'b0, r_rv, f_rv}, 9'b0);
  endtask

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; resp_ready = 0;
    a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
    rr_pref = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rr", {r_rv, r_id, r_err, r_busy, r_rdy0, r_rdy1, 3'b0}, 9'b0);
    chk("reset_dat", {1'b0, r_dat}, 9'b0);
    chk("reset_fp", {f_rv, f_id, f_err, f_busy, f_dat[4:0]}, 9'b0);
    rst = 1'b0;

    // ADD 3+5 from req0
    v0 = 1; a0 = 3; b0 = 5; c0 = 0; transact(0, 0);
    // SUB 2-5 and MUL 15*15 from req1
    v1 = 1; a1 = 2; b1 = 5; c1 = 1; transact(0, 0);
    v1 = 1; a1 = 15; b1 = 15; c1 = 2; transact(0, 0);
    // Contention held across four grants
    v0 = 1; a0 = 1; b0 = 2; c0 = 0; v1 = 1; a1 = 9; b1 = 4; c1 = 1;
    repeat (4) transact(0, 1);
    v0 = 0; v1 = 0;
    // NAND held in RESP for five cycles
    v0 = 1; a0 = 4'hC; b0 = 4'hA; c0 = 3; transact(5, 0);
    // Illegal opcode then NOR 0,0
    v1 = 1; a1 = 3; b1 = 3; c1 = 6; transact(1, 0);
    v0 = 1; a0 = 0; b0 = 0; c0 = 4; transact(0, 0);

    // Reset during EXEC discards the command and clears the pointer
    v0 = 1; a0 = 7; b0 = 7; c0 = 2;
    #1; @(posedge clk); #1;
    v0 = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_pref = 1'b0;
    chk("rst_busy", {7'b0, r_busy, f_busy}, 9'b0);
    chk("rst_rv", {7'b0, r_rv, f_rv}, 9'b0);
    chk("rst_dat", {1'b0, r_dat}, 9'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_resp", {7'b0, r_rv, f_rv}, 9'b0);
    end
    v0 = 1; a0 = 5; b0 = 6; c0 = 1; v1 = 1; a1 = 2; b1 = 3; c1 = 2;
    transact(0, 0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom % 2); v1 = 1'($urandom % 2);
      if (!v0 && !v1) v0 = 1'b1;
      a0 = 4'($urandom); b0 = 4'($urandom); c0 = 3'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); c1 = 3'($urandom);
      transact(int'($urandom_range(0, 3)), 1'($urandom % 2));
    end
    v0 = 0; v1 = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
